// File: rtl/pulse_timer_if.sv
// Configuration and status bundle for the pulse timer: frame/window setup in,
// pulse train and handshake strobes out.
interface pulse_timer_if;
    logic        enable;
    logic [31:0] period;
    logic [31:0] condition_lower;
    logic [31:0] condition_upper;
    logic        pulse_out;
    logic        frame_start;
    logic        update_ack;
    logic        busy;
    logic        cfg_error;
    logic [15:0] pulse_count;

    // Drives configuration, observes status
    modport master (
        output enable, period, condition_lower, condition_upper,
        input  pulse_out, frame_start, update_ack, busy, cfg_error, pulse_count
    );

    // The timer itself
    modport slave (
        input  enable, period, condition_lower, condition_upper,
        output pulse_out, frame_start, update_ack, busy, cfg_error, pulse_count
    );
endinterface

// File: rtl/pulse_timer.sv
// Frame-based pulse generator. A free-running counter spans one frame of
// shadow_period cycles; pulse_out is high one cycle after the counter sits
// inside [shadow_lower, shadow_upper). Configuration is double-buffered in
// shadow registers and only swapped at LOAD or at a frame wrap.
module pulse_timer (
    input  logic           clk,
    input  logic           reset,
    pulse_timer_if.slave   bus
);

    localparam int unsigned CNT_W = 32;
    localparam int unsigned PC_W  = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [CNT_W-1:0]  shd_period_q, shd_period_d;
    logic [CNT_W-1:0]  shd_lower_q, shd_lower_d;
    logic [CNT_W-1:0]  shd_upper_q, shd_upper_d;
    logic              pulse_q, pulse_d;
    logic              frame_start_q, frame_start_d;
    logic              update_ack_q, update_ack_d;
    logic              busy_q, busy_d;
    logic              cfg_error_q, cfg_error_d;
    logic [PC_W-1:0]   pulse_count_q, pulse_count_d;

    logic              period_ok_c;
    logic              new_cfg_bad_c;
    logic              cfg_changed_c;
    logic              wrap_c;
    logic              in_window_c;

    // Decode helpers on the live inputs and current shadows
    always_comb begin
        period_ok_c   = (bus.period >= CNT_W'(2));
        new_cfg_bad_c = (bus.condition_lower >= bus.condition_upper) ||
                        (bus.condition_lower >= bus.period);
        cfg_changed_c = (bus.period          != shd_period_q) ||
                        (bus.condition_lower != shd_lower_q)  ||
                        (bus.condition_upper != shd_upper_q);
        wrap_c        = (count_q == (shd_period_q - CNT_W'(1)));
        in_window_c   = (shd_lower_q <= count_q) && (count_q < shd_upper_q);
    end

    // Next-state, counter, shadow and output logic
    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        shd_period_d  = shd_period_q;
        shd_lower_d   = shd_lower_q;
        shd_upper_d   = shd_upper_q;
        update_ack_d  = 1'b0;
        cfg_error_d   = cfg_error_q;

        case (state_q)
            ST_IDLE: begin
                count_d = '0;
                if (bus.enable) begin
                    state_d = ST_LOAD;
                end
            end

            ST_LOAD: begin
                count_d = '0;
                if (!period_ok_c) begin
                    // Unusable frame length: never start running on it
                    state_d     = ST_IDLE;
                    cfg_error_d = 1'b1;
                end else begin
                    shd_period_d = bus.period;
                    shd_lower_d  = bus.condition_lower;
                    shd_upper_d  = bus.condition_upper;
                    update_ack_d = 1'b1;
                    cfg_error_d  = new_cfg_bad_c;
                    state_d      = ST_RUN;
                end
            end

            ST_RUN: begin
                if (!wrap_c) begin
                    count_d = count_q + CNT_W'(1);
                end else begin
                    count_d = '0;
                    if (!bus.enable) begin
                        state_d = ST_IDLE;
                    end else if (!period_ok_c) begin
                        // Keep running on the old shadows, flag the bad request
                        cfg_error_d = 1'b1;
                    end else if (cfg_changed_c) begin
                        shd_period_d = bus.period;
                        shd_lower_d  = bus.condition_lower;
                        shd_upper_d  = bus.condition_upper;
                        update_ack_d = 1'b1;
                        cfg_error_d  = new_cfg_bad_c;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
                count_d = '0;
            end
        endcase

        // Pulse is suppressed on the edge that leaves RUN so IDLE is always quiet
        pulse_d       = (state_q == ST_RUN) && (state_d == ST_RUN) && in_window_c;
        frame_start_d = (state_d == ST_RUN) && (count_d == '0);
        busy_d        = (state_d != ST_IDLE);

        pulse_count_d = pulse_count_q;
        if (pulse_d && !pulse_q && (pulse_count_q != {PC_W{1'b1}})) begin
            pulse_count_d = pulse_count_q + PC_W'(1);
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            count_q       <= '0;
            shd_period_q  <= '0;
            shd_lower_q   <= '0;
            shd_upper_q   <= '0;
            pulse_q       <= 1'b0;
            frame_start_q <= 1'b0;
            update_ack_q  <= 1'b0;
            busy_q        <= 1'b0;
            cfg_error_q   <= 1'b0;
            pulse_count_q <= '0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            shd_period_q  <= shd_period_d;
            shd_lower_q   <= shd_lower_d;
            shd_upper_q   <= shd_upper_d;
            pulse_q       <= pulse_d;
            frame_start_q <= frame_start_d;
            update_ack_q  <= update_ack_d;
            busy_q        <= busy_d;
            cfg_error_q   <= cfg_error_d;
            pulse_count_q <= pulse_count_d;
        end
    end

    assign bus.pulse_out   = pulse_q;
    assign bus.frame_start = frame_start_q;
    assign bus.update_ack  = update_ack_q;
    assign bus.busy        = busy_q;
    assign bus.cfg_error   = cfg_error_q;
    assign bus.pulse_count = pulse_count_q;

endmodule
